// File: rtl/uart_receiver.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling FSM and a single-entry
// output register with valid/ack handshake, frame-error and overrun pulses.
module uart_receiver #(
  parameter int unsigned CLKS_PER_BIT = 10416
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RsRx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ack,
  output logic       frame_err,
  output logic       overrun,
  output logic       busy
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CntW-1:0] CntFull = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntHalf = CntW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StWaitHigh
  } state_e;

  state_e          r_state;
  logic [CntW-1:0] r_cnt;
  logic [2:0]      r_idx;
  logic [7:0]      r_shift;
  logic            r_sync1;
  logic            r_sync2;
  logic [7:0]      r_data;
  logic            r_valid;
  logic            r_frame_err;
  logic            r_overrun;
  logic            w_rx_s;

  assign w_rx_s    = r_sync2;
  assign data      = r_data;
  assign valid     = r_valid;
  assign frame_err = r_frame_err;
  assign overrun   = r_overrun;
  assign busy      = (r_state != StIdle);

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= RsRx;
      r_sync2 <= r_sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_cnt       <= '0;
      r_idx       <= 3'd0;
      r_shift     <= 8'h00;
      r_data      <= 8'h00;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
      // A byte accepted in StStop this cycle overrides the ack-driven clear.
      if (r_valid && ack) begin
        r_valid <= 1'b0;
      end

      case (r_state)
        StIdle: begin
          r_cnt <= '0;
          if (!w_rx_s) begin
            r_state <= StStart;
          end
        end

        StStart: begin
          if (r_cnt == CntHalf) begin
            r_cnt <= '0;
            r_idx <= 3'd0;
            r_state <= w_rx_s ? StIdle : StData;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StData: begin
          if (r_cnt == CntFull) begin
            r_cnt   <= '0;
            r_shift <= {w_rx_s, r_shift[7:1]};
            if (r_idx == 3'd7) begin
              r_state <= StStop;
            end else begin
              r_idx <= r_idx + 3'd1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StStop: begin
          if (r_cnt == CntFull) begin
            r_cnt <= '0;
            if (w_rx_s) begin
              r_data    <= r_shift;
              r_valid   <= 1'b1;
              r_overrun <= r_valid & ~ack;
              r_state   <= StIdle;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= StWaitHigh;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end

        StWaitHigh: begin
          r_cnt <= '0;
          if (w_rx_s) begin
            r_state <= StIdle;
          end
        end

        default: begin
          r_cnt   <= '0;
          r_state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_receiver.sv
// Scoreboard bench for uart_receiver at CLKS_PER_BIT=16: bytes queued at send time are
// checked against each delivered byte; error/overrun pulses and timing checked per scenario.
module tb_uart_receiver;

  localparam int unsigned Cpb = 16;

  logic       clk;
  logic       rst_n;
  logic       RsRx;
  logic [7:0] data;
  logic       valid;
  logic       ack;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         n_rx = 0;
  int         n_ovr = 0;
  int         n_fe = 0;
  int         last_rx_cyc = 0;
  int         t_start = 0;
  logic [7:0] exp_q[$];
  bit         ack_mode = 0;
  bit         ack_pend = 0;
  logic       valid_prev = 1'b0;
  logic [7:0] data_prev = 8'h00;

  uart_receiver #(
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .RsRx     (RsRx),
    .data     (data),
    .valid    (valid),
    .ack      (ack),
    .frame_err(frame_err),
    .overrun  (overrun),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Monitor: a delivered byte is a rise of valid or a change of data while valid.
  always @(posedge clk) begin
    #1;
    if (rst_n) begin
      if (overrun) n_ovr++;
      if (frame_err) n_fe++;
      if (valid && (!valid_prev || data != data_prev)) begin
        n_rx++;
        last_rx_cyc = cyc;
        if (exp_q.size() == 0) check("sb_underflow", exp_q.size(), 1);
        else check("rx_byte", 32'(data), 32'(exp_q.pop_front()));
        if (ack_mode) ack_pend = 1;
      end
      valid_prev = valid;
      data_prev  = data;
    end else begin
      valid_prev = 1'b0;
      data_prev  = 8'h00;
    end
  end

  always @(negedge clk) begin
    ack = ack_pend;
    ack_pend = 0;
  end

  // Caller is aligned to a negedge; each bit lasts exactly Cpb cycles.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] fr;
    fr = {stop_bit, b, 1'b0};
    if (stop_bit) exp_q.push_back(b);
    t_start = cyc + 1;
    for (int i = 0; i < 10; i++) begin
      RsRx = fr[i];
      repeat (Cpb) @(negedge clk);
    end
  endtask

  task automatic wait_rx(input int target);
    int budget;
    budget = 40 * Cpb;
    while (n_rx < target && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    if (n_rx < target) check("rx_timeout", n_rx, target);
  endtask

  task automatic do_ack();
    @(posedge clk);
    #2 ack_pend = 1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int ovr0, fe0, rx0, lat;
    bit saw_busy;
    logic [9:0] fr;

    rst_n = 1'b0;
    RsRx  = 1'b1;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_data", 32'(data), 32'h00);
    check("rst_valid", 32'(valid), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_fe", 32'(frame_err), 0);
    check("rst_ovr", 32'(overrun), 0);
    rst_n = 1'b1;
    repeat (2 * Cpb) @(negedge clk);

    // Single byte, ack held low, latency window.
    ovr0 = n_ovr; fe0 = n_fe;
    send_frame(8'h48, 1'b1);
    wait_rx(1);
    lat = last_rx_cyc - t_start;
    check("latency_154pm1", 32'((lat >= 153) && (lat <= 155)), 1);
    check("b1_valid", 32'(valid), 1);
    check("b1_data", 32'(data), 32'h48);
    check("b1_fe", n_fe - fe0, 0);
    check("b1_ovr", n_ovr - ovr0, 0);
    do_ack();
    check("b1_ack_clears", 32'(valid), 0);
    check("b1_data_kept", 32'(data), 32'h48);

    // "Hello" back-to-back with automatic ack.
    ovr0 = n_ovr; ack_mode = 1;
    send_frame(8'h48, 1'b1);
    send_frame(8'h65, 1'b1);
    send_frame(8'h6C, 1'b1);
    send_frame(8'h6C, 1'b1);
    send_frame(8'h6F, 1'b1);
    wait_rx(6);
    repeat (4) @(negedge clk);
    ack_mode = 0;
    check("hello_count", n_rx, 6);
    check("hello_ovr", n_ovr - ovr0, 0);
    check("hello_valid_acked", 32'(valid), 0);

    // Overrun: two bytes without ack.
    ovr0 = n_ovr;
    send_frame(8'h55, 1'b1);
    send_frame(8'hAA, 1'b1);
    wait_rx(8);
    repeat (2) @(negedge clk);
    check("ovr_data", 32'(data), 32'hAA);
    check("ovr_valid", 32'(valid), 1);
    check("ovr_pulses", n_ovr - ovr0, 1);
    do_ack();

    // Framing error followed by a held-low break, then a good frame.
    fe0 = n_fe; rx0 = n_rx;
    send_frame(8'h21, 1'b0);
    RsRx = 1'b0;
    repeat (40 * Cpb) @(negedge clk);
    RsRx = 1'b1;
    repeat (3 * Cpb) @(negedge clk);
    check("fe_pulses", n_fe - fe0, 1);
    check("fe_valid", 32'(valid), 0);
    check("fe_no_byte", n_rx - rx0, 0);
    send_frame(8'h0D, 1'b1);
    wait_rx(rx0 + 1);
    check("fe_next_data", 32'(data), 32'h0D);
    do_ack();

    // Start-bit glitch of 4 cycles.
    fe0 = n_fe; rx0 = n_rx; saw_busy = 0;
    RsRx = 1'b0;
    repeat (4) @(negedge clk);
    RsRx = 1'b1;
    repeat (24) begin
      @(negedge clk);
      if (busy) saw_busy = 1;
    end
    check("glitch_busy_seen", 32'(saw_busy), 1);
    check("glitch_busy_idle", 32'(busy), 0);
    check("glitch_valid", 32'(valid), 0);
    check("glitch_fe", n_fe - fe0, 0);
    check("glitch_no_byte", n_rx - rx0, 0);

    // Reset during bit 3 of a frame, then a clean 8'h0A.
    rx0 = n_rx;
    fr = {1'b1, 8'hF3, 1'b0};
    for (int i = 0; i < 4; i++) begin
      RsRx = fr[i];
      repeat (Cpb) @(negedge clk);
    end
    RsRx = fr[4];
    repeat (Cpb / 2) @(negedge clk);
    check("pre_rst_busy", 32'(busy), 1);
    rst_n = 1'b0;
    RsRx  = 1'b1;
    #1;
    check("mid_rst_data", 32'(data), 32'h00);
    check("mid_rst_valid", 32'(valid), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_fe", 32'(frame_err), 0);
    check("mid_rst_ovr", 32'(overrun), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2 * Cpb) @(negedge clk);
    check("post_rst_no_byte", n_rx - rx0, 0);
    send_frame(8'h0A, 1'b1);
    wait_rx(rx0 + 1);
    repeat (2 * Cpb) @(negedge clk);
    check("rst_only_0a", n_rx - rx0, 1);
    check("rst_data_0a", 32'(data), 32'h0A);

    check("sb_left", exp_q.size(), 0);
    check("total_bytes", n_rx, 10);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
